// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one pipeline request at a time, drives a
// request/grant/rvalid data-memory port and returns aligned, extended load data.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_size;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_accept;
  logic          w_bad_in;
  logic          w_in_mem;
  logic          w_timeout;
  logic [31:0]   w_shifted;
  logic [31:0]   w_load_data;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;

  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_in_mem  = (r_state == REQ) || (r_state == WAIT);
  assign w_timeout = w_in_mem && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Alignment is judged on the incoming request so a bad access skips the memory port.
  always_comb begin
    w_bad_in = 1'b0;
    case (req_size)
      3'b000:         w_bad_in = (req_addr[1:0] != 2'b00);
      3'b001, 3'b011: w_bad_in = req_addr[0];
      3'b010, 3'b100: w_bad_in = 1'b0;
      default:        w_bad_in = 1'b1;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = w_bad_in ? RESP : REQ;
      REQ: begin
        if (w_timeout)    w_state_next = RESP;
        else if (mem_gnt) w_state_next = WAIT;
      end
      WAIT: begin
        if (w_timeout || mem_rvalid) w_state_next = RESP;
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_shifted   = mem_rdata >> {r_addr[1:0], 3'b000};
    w_load_data = 32'd0;
    case (r_size)
      3'b000:  w_load_data = w_shifted;
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b011:  w_load_data = {16'd0, w_shifted[15:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      default: w_load_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_size  <= 3'd0;
      r_cnt   <= '0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_size  <= req_size;
      r_cnt   <= '0;
      r_rdata <= 32'd0;
      r_err   <= w_bad_in;
    end else if (w_in_mem) begin
      r_cnt <= r_cnt + CW'(1);
      // Timeout takes priority over a grant or completion in the same cycle.
      if (w_timeout) begin
        r_err   <= 1'b1;
        r_rdata <= 32'd0;
      end else if ((r_state == WAIT) && mem_rvalid) begin
        r_err   <= 1'b0;
        r_rdata <= r_we ? 32'd0 : w_load_data;
      end
    end
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'd0;
    case (r_size)
      3'b000: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
      3'b001, 3'b011: begin
        w_be    = 4'b0011 << r_addr[1:0];
        w_wdata = {2{r_wdata[15:0]}};
      end
      3'b010, 3'b100: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = 32'd0;
      end
    endcase
  end

  // Memory-side fields are only driven while requesting, so they read as zero otherwise.
  assign mem_req    = (r_state == REQ);
  assign mem_we     = mem_req && r_we;
  assign mem_addr   = mem_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_be     = mem_req ? w_be : 4'b0000;
  assign mem_wdata  = mem_req ? w_wdata : 32'd0;

  assign resp_valid = (r_state == RESP);
  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = resp_valid ? r_rdata : 32'd0;

  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a transaction-level model sets per-cycle expectations
// and a single compare process checks the DUT against them on every falling edge.
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // per-cycle expectations
  bit          chk_en = 1'b0;
  logic        e_ready, e_busy, e_mreq, e_mwe, e_rvalid, e_rerr;
  logic [31:0] e_maddr, e_mwd, e_rdata;
  logic [3:0]  e_mbe;

  // observations of the latest transaction
  bit          cap_mreq_seen;
  logic [3:0]  cap_be;
  logic [31:0] cap_wd, cap_rdata;
  logic        cap_we, cap_err;
  int          cap_resp_cyc;
  int          last_acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("mem_req", 32'(mem_req), 32'(e_mreq));
      chk("resp_valid", 32'(resp_valid), 32'(e_rvalid));
      if (e_mreq) begin
        chk("mem_we", 32'(mem_we), 32'(e_mwe));
        chk("mem_addr", mem_addr, e_maddr);
        chk("mem_be", 32'(mem_be), 32'(e_mbe));
        chk("mem_wdata", mem_wdata, e_mwd);
      end
      if (e_rvalid) begin
        chk("resp_err", 32'(resp_err), 32'(e_rerr));
        chk("resp_rdata", resp_rdata, e_rdata);
      end
      if (mem_req) begin
        cap_mreq_seen = 1'b1;
        cap_be = mem_be;
        cap_wd = mem_wdata;
        cap_we = mem_we;
      end
      if (resp_valid) begin
        cap_rdata    = resp_rdata;
        cap_err      = resp_err;
        cap_resp_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_ready = 1'b1; e_busy = 1'b0; e_mreq = 1'b0; e_rvalid = 1'b0;
  endtask

  function automatic bit is_bad(input logic [2:0] size, input logic [31:0] addr);
    if (size > 3'd4) return 1'b1;
    if ((size == 3'd1 || size == 3'd3) && addr[0]) return 1'b1;
    if (size == 3'd0 && addr[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nbytes(input logic [2:0] size);
    if (size == 3'd0) return 4;
    if (size == 3'd1 || size == 3'd3) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] size, input logic [31:0] addr);
    int n = nbytes(size);
    int off = (n == 4) ? 0 : int'(addr[1:0]);
    logic [3:0] be = 4'b0000;
    for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] size, input logic [31:0] wd);
    int n = nbytes(size);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int n = nbytes(size);
    int off = int'(addr[1:0]);
    bit sgn = (size == 3'd1) || (size == 3'd2);
    longint v = longint'(rd) >> (8 * off);
    v = v & ((64'd1 << (8 * n)) - 1);
    if (sgn && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  // gnt_wait: REQ cycles before mem_gnt (-1 = never); rv_wait: WAIT cycles before mem_rvalid (-1 = never)
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] size, input int gnt_wait, input int rv_wait,
                         input logic [31:0] rd);
    bit bad_req = is_bad(size, addr);
    int spent = 0, k = 0, j = 0;
    bit in_wait = 1'b0, tmo = 1'b0;
    cap_mreq_seen = 1'b0;
    cap_resp_cyc  = -1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_size = size;
    set_idle();
    last_acc = cyc;
    tick();
    // scramble request inputs to prove the controller works from latched values
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd; req_size = ~size;
    e_ready = 1'b0; e_busy = 1'b1; e_rvalid = 1'b0; e_mreq = 1'b0;
    if (!bad_req) begin
      e_mwe = we; e_maddr = {addr[31:2], 2'b00};
      e_mbe = model_be(size, addr); e_mwd = model_wdata(size, wd);
      forever begin
        spent++;
        e_mreq = !in_wait;
        if (!in_wait) mem_gnt = (k == gnt_wait);
        else begin
          mem_rvalid = (j == rv_wait);
          mem_rdata  = (j == rv_wait) ? rd : 32'hDEAD_BEEF;
        end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (spent == TO) begin tmo = 1'b1; break; end
        if (!in_wait) begin
          if (k == gnt_wait) in_wait = 1'b1;
          k++;
        end else begin
          if (j == rv_wait) break;
          j++;
        end
      end
    end
    e_mreq = 1'b0; e_rvalid = 1'b1; e_rerr = bad_req || tmo;
    e_rdata = (bad_req || tmo || we) ? 32'd0 : model_load(size, addr, rd);
    tick();
    set_idle();
    $display("txn we=%0b addr=%h size=%0d -> err=%0b rdata=%h lat=%0d",
             we, addr, size, cap_err, cap_rdata, cap_resp_cyc - last_acc);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_idle();
    chk_en = 1'b1;
    tick();

    // LB 0x103
    run_txn(1'b0, 32'h103, 32'h0, 3'b010, 0, 0, 32'h80FF1234);
    chk("lb_rdata_lit", cap_rdata, 32'hFFFFFF80);
    chk("lb_be_lit", 32'(cap_be), 32'h8);
    chk("lb_latency_lit", 32'(cap_resp_cyc - last_acc), 32'd3);
    // LHU 0x102
    run_txn(1'b0, 32'h102, 32'h0, 3'b011, 0, 0, 32'hBEEF0000);
    chk("lhu_rdata_lit", cap_rdata, 32'h0000BEEF);
    chk("lhu_be_lit", 32'(cap_be), 32'hC);
    // SB 0x101
    run_txn(1'b1, 32'h101, 32'h000000A5, 3'b010, 0, 0, 32'h0);
    chk("sb_wdata_lit", cap_wd, 32'hA5A5A5A5);
    chk("sb_be_lit", 32'(cap_be), 32'h2);
    chk("sb_we_lit", 32'(cap_we), 32'd1);
    chk("sb_rdata_lit", cap_rdata, 32'd0);
    // LW 0x102 misaligned
    run_txn(1'b0, 32'h102, 32'h0, 3'b000, 0, 0, 32'h0);
    chk("lw_mis_err_lit", 32'(cap_err), 32'd1);
    chk("lw_mis_latency_lit", 32'(cap_resp_cyc - last_acc), 32'd1);
    chk("lw_mis_no_mreq_lit", 32'(cap_mreq_seen), 32'd0);
    // grant never arrives
    run_txn(1'b0, 32'h200, 32'h0, 3'b000, -1, 0, 32'h0);
    chk("tmo_err_lit", 32'(cap_err), 32'd1);
    chk("tmo_latency_lit", 32'(cap_resp_cyc - last_acc), 32'd5);

    run_txn(1'b1, 32'h302, 32'h1234ABCD, 3'b001, 0, 0, 32'h0);
    chk("sh_wdata_lit", cap_wd, 32'hABCDABCD);
    run_txn(1'b1, 32'h300, 32'hCAFEF00D, 3'b000, 1, 0, 32'h0);
    run_txn(1'b0, 32'h100, 32'h0, 3'b001, 0, 1, 32'h00008001);
    chk("lh_rdata_lit", cap_rdata, 32'hFFFF8001);
    run_txn(1'b0, 32'h101, 32'h0, 3'b100, 0, 0, 32'h0000F000);
    chk("lbu_rdata_lit", cap_rdata, 32'h000000F0);
    run_txn(1'b0, 32'h104, 32'h0, 3'b000, 1, 0, 32'h13579BDF);
    run_txn(1'b0, 32'h100, 32'h0, 3'b101, 0, 0, 32'h0);
    run_txn(1'b1, 32'h101, 32'h5555, 3'b001, 0, 0, 32'h0);
    run_txn(1'b0, 32'h103, 32'h0, 3'b011, 0, 0, 32'h0);
    run_txn(1'b0, 32'h400, 32'h0, 3'b000, 0, -1, 32'h0);
    run_txn(1'b0, 32'h400, 32'h0, 3'b000, 3, 0, 32'h0);
    chk("gnt_vs_tmo_err_lit", 32'(cap_err), 32'd1);

    // reset while waiting for completion, then a stale rvalid
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h500; req_size = 3'b000;
    set_idle();
    tick();
    req_valid = 1'b0;
    e_ready = 1'b0; e_busy = 1'b1; e_mreq = 1'b1; e_mwe = 1'b0;
    e_maddr = 32'h500; e_mbe = 4'hF; e_mwd = model_wdata(3'b000, req_wdata);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    e_mreq = 1'b0;
    tick();
    rst_n = 1'b0;
    set_idle();
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_be", 32'(mem_be), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("stale_resp_valid", 32'(resp_valid), 32'd0);
    chk("stale_req_ready", 32'(req_ready), 32'd1);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
